alu_flag_stage: RTL and testbench

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

---
 rtl/alu_flag_stage_pkg.sv | 50 +++++
 rtl/alu_flag_stage_if.sv | 32 +++
 rtl/alu_flag_stage_br_cond.sv | 34 +++
 rtl/alu_flag_stage.sv | 78 +++++++
 tb/tb_alu_flag_stage.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_flag_stage_pkg.sv
// Shared types and constants for the EX/MEM flag stage.
// Opcode map, branch condition codes and flag bit positions.
package alu_flag_stage_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int OP_W   = 4;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef logic [2:0] flag_t;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
   localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
   localparam logic [OP_W-1:0] OP_ROR = 4'b0110;

   typedef enum logic [2:0] {
      CC_NE = 3'b000,
      CC_EQ = 3'b001,
      CC_GT = 3'b010,
      CC_LT = 3'b011,
      CC_GE = 3'b100,
      CC_LE = 3'b101,
      CC_VS = 3'b110,
      CC_AL = 3'b111
   } ccc_e;

   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Which flag bits an opcode is allowed to overwrite.
   function automatic flag_t flag_mask(input logic [OP_W-1:0] op);
      flag_t m;
      m = '0;
      case (op)
         OP_ADD, OP_SUB: m = 3'b111;
         OP_XOR, OP_SLL,
         OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_flag_stage_if.sv
// EX-stage bundle in, EX/MEM pipeline register out.
// master drives the EX side, slave is the stage.
interface alu_flag_stage_if;
   import alu_flag_stage_pkg::*;

   logic              ex_valid;
   logic [OP_W-1:0]   ex_opcode;
   logic [DATA_W-1:0] ex_result;
   flag_t             ex_flag;
   logic              ex_wr_en;
   logic [REG_W-1:0]  ex_wr_reg;

   logic              mem_valid;
   logic [DATA_W-1:0] mem_result;
   logic              mem_wr_en;
   logic [REG_W-1:0]  mem_wr_reg;

   modport master (
      output ex_valid, ex_opcode, ex_result,
      output ex_flag, ex_wr_en, ex_wr_reg,
      input  mem_valid, mem_result,
      input  mem_wr_en, mem_wr_reg
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_result,
      input  ex_flag, ex_wr_en, ex_wr_reg,
      output mem_valid, mem_result,
      output mem_wr_en, mem_wr_reg
   );

endinterface

// File: rtl/alu_flag_stage_br_cond.sv
// Branch condition evaluator: (ccc, {N,V,Z}) -> taken.
// Pure combinational, shared with the decode stage.
module alu_flag_stage_br_cond
   import alu_flag_stage_pkg::*;
(
   input  ccc_e  ccc,
   input  flag_t flags,
   output logic  taken
);

   logic n;
   logic v;
   logic z;

   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];
   assign z = flags[FLAG_Z];

   // Decode the condition code against the supplied flags.
   always_comb begin
      taken = 1'b0;
      unique case (ccc)
         CC_NE: taken = ~z;
         CC_EQ: taken = z;
         CC_GT: taken = ~z & ~n;
         CC_LT: taken = n;
         CC_GE: taken = z | (~z & ~n);
         CC_LE: taken = n | z;
         CC_VS: taken = v;
         CC_AL: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_flag_stage.sv
// EX/MEM register with architectural flag update,
// same-cycle flag bypass to decode, and overflow counter.
module alu_flag_stage
   import alu_flag_stage_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             br_eval,
   input  logic [2:0]       br_ccc,
   output flag_t            flag_q,
   output logic             br_taken,
   output logic [CNT_W-1:0] ovfl_count,
   alu_flag_stage_if.slave  ex_mem
);

   logic  commit;
   flag_t mask;
   flag_t flag_next;
   logic  ovfl_hit;
   logic  cond_taken;

   assign commit = ex_mem.ex_valid & ~stall & ~flush;
   assign mask   = flag_mask(ex_mem.ex_opcode);

   // Merge the opcode's writable flag bits over the current flags.
   always_comb begin
      flag_next = flag_q;
      if (commit)
         flag_next = (flag_q & ~mask) | (ex_mem.ex_flag & mask);
   end

   assign ovfl_hit = commit
                   & is_arith(ex_mem.ex_opcode)
                   & ex_mem.ex_flag[FLAG_V];

   alu_flag_stage_br_cond u_br_cond (
      .ccc   (ccc_e'(br_ccc)),
      .flags (flag_next),
      .taken (cond_taken)
   );

   assign br_taken = br_eval & cond_taken;

   // Flag register and saturating overflow counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q     <= '0;
         ovfl_count <= '0;
      end else begin
         flag_q <= flag_next;
         if (ovfl_hit && !(&ovfl_count))
            ovfl_count <= ovfl_count + 1'b1;
      end
   end

   // EX/MEM pipeline register: flush squashes, stall holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem.mem_valid  <= 1'b0;
         ex_mem.mem_result <= '0;
         ex_mem.mem_wr_en  <= 1'b0;
         ex_mem.mem_wr_reg <= '0;
      end else if (flush) begin
         ex_mem.mem_valid <= 1'b0;
         ex_mem.mem_wr_en <= 1'b0;
      end else if (!stall) begin
         ex_mem.mem_valid  <= ex_mem.ex_valid;
         ex_mem.mem_result <= ex_mem.ex_result;
         ex_mem.mem_wr_en  <= ex_mem.ex_wr_en & ex_mem.ex_valid;
         ex_mem.mem_wr_reg <= ex_mem.ex_wr_reg;
      end
   end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Self-checking bench for alu_flag_stage.
// Directed scenarios plus randomized traffic vs a reference model.
module tb_alu_flag_stage;

   localparam int CNT_W = 6;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             flush;
   logic             br_eval;
   logic [2:0]       br_ccc;
   logic [2:0]       flag_q;
   logic             br_taken;
   logic [CNT_W-1:0] ovfl_count;

   alu_flag_stage_if bus ();

   alu_flag_stage #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .br_eval    (br_eval),
      .br_ccc     (br_ccc),
      .flag_q     (flag_q),
      .br_taken   (br_taken),
      .ovfl_count (ovfl_count),
      .ex_mem     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   // Reference state
   logic [2:0]  m_flag  = 3'b000;
   int          m_count = 0;
   logic        m_valid = 1'b0;
   logic        m_we    = 1'b0;
   logic [15:0] m_res   = 16'h0;
   logic [3:0]  m_reg   = 4'h0;
   bit          m_dc    = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Flags {N,V,Z} after an instruction, from the opcode rules.
   function automatic logic [2:0] upd_flags(input logic [2:0] f,
                                            input logic c,
                                            input logic [3:0] op,
                                            input logic [2:0] ef);
      if (!c) return f;
      if (op == 4'd0 || op == 4'd1) return ef;
      if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)
         return {f[2], f[1], ef[0]};
      return f;
   endfunction

   function automatic logic cond(input logic [2:0] c,
                                 input logic [2:0] f);
      logic n, v, z;
      n = f[2];
      v = f[1];
      z = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic commit_now();
      return bus.ex_valid && !stall && !flush;
   endfunction

   // Model update at each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         m_flag  <= 3'b000;
         m_count <= 0;
         m_valid <= 1'b0;
         m_we    <= 1'b0;
         m_res   <= 16'h0;
         m_reg   <= 4'h0;
         m_dc    <= 1'b0;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_we    <= 1'b0;
         m_dc    <= 1'b1;
      end else if (!stall) begin
         m_valid <= bus.ex_valid;
         m_we    <= bus.ex_valid && bus.ex_wr_en;
         m_res   <= bus.ex_result;
         m_reg   <= bus.ex_wr_reg;
         m_dc    <= 1'b0;
         m_flag  <= upd_flags(m_flag, bus.ex_valid,
                              bus.ex_opcode, bus.ex_flag);
         if (bus.ex_valid && bus.ex_opcode <= 4'd1 &&
             bus.ex_flag[1] && m_count < CMAX)
            m_count <= m_count + 1;
      end
   end

   // Compare DUT against the model mid-cycle.
   always @(negedge clk) begin
      if (started) begin
         if (!rst)
            check("br_taken", {31'd0, br_taken},
                  {31'd0, br_eval && cond(br_ccc,
                     upd_flags(m_flag, commit_now(),
                               bus.ex_opcode, bus.ex_flag))});
         check("flag_q", {29'd0, flag_q}, {29'd0, m_flag});
         check("ovfl_count", 32'(ovfl_count), 32'(m_count));
         check("mem_valid", {31'd0, bus.mem_valid}, {31'd0, m_valid});
         check("mem_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, m_we});
         if (!m_dc) begin
            check("mem_result", {16'd0, bus.mem_result}, {16'd0, m_res});
            check("mem_wr_reg", {28'd0, bus.mem_wr_reg}, {28'd0, m_reg});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic [2:0] f,
                         input logic we, input logic [3:0] rg);
      bus.ex_valid  = v;
      bus.ex_opcode = op;
      bus.ex_result = res;
      bus.ex_flag   = f;
      bus.ex_wr_en  = we;
      bus.ex_wr_reg = rg;
   endtask

   task automatic idle();
      set_ex(1'b0, 4'hF, 16'h0, 3'b000, 1'b0, 4'h0);
      br_eval = 1'b0;
      br_ccc  = 3'b000;
   endtask

   initial begin
      rst   = 1'b1;
      stall = 1'b1;
      flush = 1'b0;
      idle();
      step();
      started = 1'b1;
      step();
      rst   = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      check("rst_flag", {29'd0, flag_q}, 32'h0);
      check("rst_valid", {31'd0, bus.mem_valid}, 32'h0);
      check("rst_cnt", 32'(ovfl_count), 32'h0);

      // SUB result zero bypassed to a BEQ in decode
      step();
      set_ex(1'b1, 4'b0001, 16'h0000, 3'b001, 1'b1, 4'd3);
      br_eval = 1'b1;
      br_ccc  = 3'b001;
      @(negedge clk);
      check("sub_beq_taken", {31'd0, br_taken}, 32'h1);
      step();
      idle();
      @(negedge clk);
      check("sub_flag", {29'd0, flag_q}, 32'h1);
      check("sub_res", {16'd0, bus.mem_result}, 32'h0);

      // XOR updates Z only
      step();
      set_ex(1'b1, 4'b0000, 16'h1234, 3'b110, 1'b1, 4'd1);
      step();
      set_ex(1'b1, 4'b0010, 16'h0000, 3'b001, 1'b1, 4'd2);
      @(negedge clk);
      check("add_flag", {29'd0, flag_q}, 32'h6);
      step();
      idle();
      @(negedge clk);
      check("xor_flag", {29'd0, flag_q}, 32'h7);
      check("xor_cnt", 32'(ovfl_count), 32'h1);

      // ADD held by stall for three edges
      step();
      set_ex(1'b1, 4'b0000, 16'hFFFF, 3'b010, 1'b1, 4'd5);
      stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_flag", {29'd0, flag_q}, 32'h7);
         check("stall_cnt", 32'(ovfl_count), 32'h1);
         step();
      end
      stall = 1'b0;
      step();
      idle();
      @(negedge clk);
      check("unstall_flag", {29'd0, flag_q}, 32'h2);
      check("unstall_cnt", 32'(ovfl_count), 32'h2);
      check("unstall_res", {16'd0, bus.mem_result}, 32'hFFFF);
      step();
      @(negedge clk);
      check("once_cnt", 32'(ovfl_count), 32'h2);

      // stall+flush squashes; branch sees old flags
      step();
      stall = 1'b1;
      flush = 1'b1;
      set_ex(1'b1, 4'b0000, 16'h0000, 3'b011, 1'b1, 4'd6);
      br_eval = 1'b1;
      br_ccc  = 3'b000;
      @(negedge clk);
      check("flush_taken", {31'd0, br_taken}, 32'h1);
      step();
      stall = 1'b0;
      flush = 1'b0;
      idle();
      @(negedge clk);
      check("flush_valid", {31'd0, bus.mem_valid}, 32'h0);
      check("flush_flag", {29'd0, flag_q}, 32'h2);
      check("flush_cnt", 32'(ovfl_count), 32'h2);

      // Counter saturation, then a load leaves flags alone
      step();
      set_ex(1'b1, 4'b0000, 16'h7FFF, 3'b010, 1'b1, 4'd7);
      repeat (70) step();
      set_ex(1'b1, 4'b1000, 16'hABCD, 3'b111, 1'b1, 4'd8);
      @(negedge clk);
      check("sat_cnt", 32'(ovfl_count), CMAX);
      step();
      idle();
      @(negedge clk);
      check("lw_flag", {29'd0, flag_q}, 32'h2);
      check("lw_cnt", 32'(ovfl_count), CMAX);

      // Reset during stall discards the held ADD
      step();
      stall = 1'b1;
      rst   = 1'b1;
      set_ex(1'b1, 4'b0000, 16'h1111, 3'b111, 1'b1, 4'd9);
      step();
      rst   = 1'b0;
      stall = 1'b0;
      idle();
      @(negedge clk);
      check("rst2_flag", {29'd0, flag_q}, 32'h0);
      check("rst2_cnt", 32'(ovfl_count), 32'h0);
      check("rst2_valid", {31'd0, bus.mem_valid}, 32'h0);

      // Randomized traffic
      repeat (4000) begin
         step();
         rst   = ($urandom_range(0, 149) == 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         set_ex($urandom_range(0, 3) != 0,
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 1))
                                            : 4'($urandom_range(0, 15)),
                16'($urandom),
                3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
         br_eval = ($urandom_range(0, 3) != 0);
         br_ccc  = 3'($urandom_range(0, 7));
      end
      step();
      rst   = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      idle();
      @(negedge clk);
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
